// File: rtl/mips_multicycle_control_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mips_multicycle_control_if                                    |
// | Purpose  : Bundles the control <-> datapath signals of the multicycle    |
// |            MIPS main controller.                                         |
// | Ports    : none (signal container)                                       |
// |   opcode[5:0]   IR[31:26], valid from DECODE onward                      |
// |   mem_ready     memory access completes this cycle                       |
// |   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,      |
// |   RegDst, RegWrite, ALUSrcA        1-bit datapath controls               |
// |   ALUSrcB[1:0], ALUop[1:0], PCSource[1:0]   mux / ALU-control selects    |
// |   state[3:0]    current FSM state (debug)                                |
// |   illegal_op    one-cycle pulse after an unknown opcode is decoded       |
// | Modports : master = controller side, slave = datapath / environment     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface mips_multicycle_control_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUop;
   logic [1:0] PCSource;
   logic [3:0] state;
   logic       illegal_op;

   modport master (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop,
             PCSource, state, illegal_op
   );

   modport slave (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop,
             PCSource, state, illegal_op
   );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mips_multicycle_control                                       |
// | Purpose  : Main control FSM of the multicycle MIPS datapath. Sequences   |
// |            fetch / decode / execute / memory / writeback from the        |
// |            opcode and drives the datapath enables and mux selects.       |
// | Ports    :                                                               |
// |   clk    in  rising-edge clock                                           |
// |   rst_n  in  asynchronous active-low reset                               |
// |   bus    mips_multicycle_control_if.master (opcode/mem_ready in,         |
// |          all datapath controls, state and illegal_op out)                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mips_multicycle_control #(
   parameter logic [5:0] OP_RTYPE = 6'd0,
   parameter logic [5:0] OP_LW    = 6'd35,
   parameter logic [5:0] OP_SW    = 6'd43,
   parameter logic [5:0] OP_BEQ   = 6'd4,
   parameter logic [5:0] OP_J     = 6'd2,
   parameter logic [5:0] OP_ADDI  = 6'd8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   mips_multicycle_control_if.master  bus
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_RTWB    = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_ADDI_EX = 4'd11,
      S_ADDI_WB = 4'd12
   } state_t;

   state_t     state_q, state_d;
   logic       illegal_q, illegal_d;

   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;

   // ------------------------------------------------------------------
   // State and illegal-opcode flag; reset clears both asynchronously so
   // every decoded output drops to 0 without waiting for a clock edge.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output decode. Outputs are a function of state only,
   // except IRWrite/PCWrite in FETCH which follow mem_ready so the IR and
   // PC load exactly once, on the cycle the fetch completes.
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      illegal_d     = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end

         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;           // PC + 4
            ir_write  = bus.mem_ready;
            pc_write  = bus.mem_ready;
            if (bus.mem_ready) begin
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            alu_src_b = 2'b11;           // precompute branch target
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDI_EX;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end

         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            // Opcode is re-sampled here; an opcode that is neither load
            // nor store can only arise from a corrupted IR, so abandon
            // the instruction rather than touch memory.
            if (bus.opcode == OP_LW) begin
               state_d = S_MEMRD;
            end else if (bus.opcode == OP_SW) begin
               state_d = S_MEMWR;
            end else begin
               state_d = S_FETCH;
            end
         end

         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (bus.mem_ready) begin
               state_d = S_MEMWB;
            end
         end

         S_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end

         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (bus.mem_ready) begin
               state_d = S_FETCH;
            end
         end

         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_RTWB;
         end

         S_RTWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end

         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            state_d       = S_FETCH;
         end

         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = S_FETCH;
         end

         S_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_ADDI_WB;
         end

         S_ADDI_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end

         // Unused encodings 13-15: outputs stay 0, recover via FETCH.
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign bus.PCWrite     = pc_write;
   assign bus.PCWriteCond = pc_write_cond;
   assign bus.IorD        = iord;
   assign bus.MemRead     = mem_read;
   assign bus.MemWrite    = mem_write;
   assign bus.IRWrite     = ir_write;
   assign bus.MemtoReg    = mem_to_reg;
   assign bus.RegDst      = reg_dst;
   assign bus.RegWrite    = reg_write;
   assign bus.ALUSrcA     = alu_src_a;
   assign bus.ALUSrcB     = alu_src_b;
   assign bus.ALUop       = alu_op;
   assign bus.PCSource    = pc_source;
   assign bus.state       = state_q;
   assign bus.illegal_op  = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mips_multicycle_control                                    |
// | Purpose  : Self-checking bench for mips_multicycle_control. Expected     |
// |            output vectors are queued as stimulus is applied and popped   |
// |            for comparison when the outputs are sampled.                  |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mips_multicycle_control;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   logic [20:0] sb_q[$];

   mips_multicycle_control_if bus ();

   mips_multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference output vector for a given state, straight from the state table.
   function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic mr, input logic ill);
      logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
      logic [1:0] srcb, aop, psrc;
      {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = 10'b0;
      srcb = 2'b00;
      aop  = 2'b00;
      psrc = 2'b00;
      case (st)
         4'd1:  begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
         4'd2:  begin srcb = 2'b11; end
         4'd3:  begin srca = 1'b1; srcb = 2'b10; end
         4'd4:  begin mrd = 1'b1; iord = 1'b1; end
         4'd5:  begin m2r = 1'b1; rw = 1'b1; end
         4'd6:  begin mwr = 1'b1; iord = 1'b1; end
         4'd7:  begin srca = 1'b1; aop = 2'b10; end
         4'd8:  begin rdst = 1'b1; rw = 1'b1; end
         4'd9:  begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
         4'd10: begin pcw = 1'b1; psrc = 2'b10; end
         4'd11: begin srca = 1'b1; srcb = 2'b10; end
         4'd12: begin rw = 1'b1; end
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca,
              srcb, aop, psrc, st, ill};
   endfunction

   function automatic logic [20:0] act_vec();
      return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
              bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
              bus.ALUSrcB, bus.ALUop, bus.PCSource, bus.state, bus.illegal_op};
   endfunction

   // Apply one cycle of stimulus and queue what the outputs must be.
   task automatic drive(input logic [5:0] op, input logic mr, input logic [3:0] st, input logic ill);
      bus.opcode    = op;
      bus.mem_ready = mr;
      sb_q.push_back(exp_vec(st, mr, ill));
   endtask

   task automatic test_reset();
      logic [20:0] e;
      rst_n         = 1'b0;
      bus.opcode    = 6'd0;
      bus.mem_ready = 1'b1;
      sb_q.push_back(21'd0);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (act_vec() !== e) begin
         failures++;
         $display("FAIL reset_state: got %h expected %h", act_vec(), e);
      end
      #2 rst_n = 1'b1;
      sb_q.push_back(exp_vec(4'd0, 1'b1, 1'b0));
      #1;
      e = sb_q.pop_front();
      checks++;
      if (act_vec() !== e) begin
         failures++;
         $display("FAIL reset_idle: got %h expected %h", act_vec(), e);
      end
      @(posedge clk);
      #1;
      sb_q.push_back(exp_vec(4'd1, 1'b1, 1'b0));
      e = sb_q.pop_front();
      checks++;
      if (act_vec() !== e) begin
         failures++;
         $display("FAIL reset_first_fetch: got %h expected %h", act_vec(), e);
      end
   endtask

   // Each scenario starts 1 time unit after a rising edge with the DUT in FETCH.
   task automatic test_rtype();
      logic [3:0] st[4] = '{4'd1, 4'd2, 4'd7, 4'd8};
      logic [20:0] e;
      for (int i = 0; i < 4; i++) begin
         drive(6'd0, 1'b1, st[i], 1'b0);
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (act_vec() !== e) begin
            failures++;
            $display("FAIL rtype cyc%0d: got %h expected %h", i, act_vec(), e);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_lw_wait();
      logic [3:0] st[7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5};
      logic       mr[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [20:0] e;
      for (int i = 0; i < 7; i++) begin
         drive(6'd35, mr[i], st[i], 1'b0);
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (act_vec() !== e) begin
            failures++;
            $display("FAIL lw_wait cyc%0d: got %h expected %h", i, act_vec(), e);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_sw_fetch_wait();
      logic [3:0] st[7] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd6, 4'd6};
      logic       mr[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [20:0] e;
      for (int i = 0; i < 7; i++) begin
         drive(6'd43, mr[i], st[i], 1'b0);
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (act_vec() !== e) begin
            failures++;
            $display("FAIL sw_fetch_wait cyc%0d: got %h expected %h", i, act_vec(), e);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] op[6] = '{6'd4, 6'd4, 6'd4, 6'd2, 6'd2, 6'd2};
      logic [3:0] st[6] = '{4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd10};
      logic [20:0] e;
      for (int i = 0; i < 6; i++) begin
         drive(op[i], 1'b1, st[i], 1'b0);
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (act_vec() !== e) begin
            failures++;
            $display("FAIL beq_j cyc%0d: got %h expected %h", i, act_vec(), e);
         end
         @(posedge clk);
         #1;
      end
   endtask

   // ADDI with the opcode changed outside DECODE; those changes must not matter.
   task automatic test_opcode_ignored();
      logic [5:0] op[4] = '{6'h3F, 6'd8, 6'd35, 6'd43};
      logic [3:0] st[4] = '{4'd1, 4'd2, 4'd11, 4'd12};
      logic [20:0] e;
      for (int i = 0; i < 4; i++) begin
         drive(op[i], 1'b1, st[i], 1'b0);
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (act_vec() !== e) begin
            failures++;
            $display("FAIL addi cyc%0d: got %h expected %h", i, act_vec(), e);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_illegal();
      logic [5:0] op[6]  = '{6'h3F, 6'h3F, 6'd0, 6'd0, 6'd0, 6'd0};
      logic [3:0] st[6]  = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd7, 4'd8};
      logic       ill[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [20:0] e;
      for (int i = 0; i < 6; i++) begin
         drive(op[i], 1'b1, st[i], ill[i]);
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (act_vec() !== e) begin
            failures++;
            $display("FAIL illegal cyc%0d: got %h expected %h", i, act_vec(), e);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] st[4] = '{4'd1, 4'd2, 4'd3, 4'd6};
      logic       mr[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [20:0] e;
      for (int i = 0; i < 4; i++) begin
         drive(6'd43, mr[i], st[i], 1'b0);
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (act_vec() !== e) begin
            failures++;
            $display("FAIL rst_sw cyc%0d: got %h expected %h", i, act_vec(), e);
         end
         if (i < 3) begin
            @(posedge clk);
            #1;
         end
      end
      // Mid low phase, well away from any rising edge.
      #2 rst_n = 1'b0;
      sb_q.push_back(21'd0);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (act_vec() !== e) begin
         failures++;
         $display("FAIL async_reset_drop: got %h expected %h", act_vec(), e);
      end
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      bus.mem_ready = 1'b1;
      sb_q.push_back(exp_vec(4'd0, 1'b1, 1'b0));
      #1;
      e = sb_q.pop_front();
      checks++;
      if (act_vec() !== e) begin
         failures++;
         $display("FAIL async_reset_idle: got %h expected %h", act_vec(), e);
      end
      @(posedge clk);
      #1;
      sb_q.push_back(exp_vec(4'd1, 1'b1, 1'b0));
      e = sb_q.pop_front();
      checks++;
      if (act_vec() !== e) begin
         failures++;
         $display("FAIL async_reset_refetch: got %h expected %h", act_vec(), e);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_sw_fetch_wait();
      test_back_to_back();
      test_opcode_ignored();
      test_illegal();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
